// File: rtl/controle_busca_raio_if.sv
`default_nettype none
// ============================================================================
// Module      : controle_busca_raio_if
// Description : Bundle between the radius-search controller and its
//               environment (start/result handshake plus the four quadrant
//               searchers).
//               master : environment side (drives start and searcher results)
//               slave  : controller side (drives radius, enables and results)
// Revision    : 1.0 - initial release
// ============================================================================
interface controle_busca_raio_if #(
   parameter int tamanhoDistancia = 8
);
   // Start request and per-quadrant searcher reports
   logic                          iniciar;
   logic [tamanhoDistancia-1:0]   raioMaximo;
   logic [3:0]                    acabouCalculoLocal;
   logic [3:0]                    operacaoFinalizada;
   logic [4*tamanhoDistancia-1:0] candidatoAtual;
   logic [4*tamanhoDistancia-1:0] coordenadaCandidatoX;
   logic [4*tamanhoDistancia-1:0] coordenadaCandidatoY;

   // Controller outputs
   logic                          enableBusca;
   logic [tamanhoDistancia-1:0]   raio;
   logic                          raioAtualizado;
   logic                          ocupado;
   logic                          pronto;
   logic                          encontrado;
   logic [tamanhoDistancia-1:0]   melhorDistancia;
   logic [tamanhoDistancia-1:0]   melhorX;
   logic [tamanhoDistancia-1:0]   melhorY;
   logic [1:0]                    melhorQuadrante;
   logic                          erroTimeout;

   modport master (
      output iniciar, raioMaximo, acabouCalculoLocal, operacaoFinalizada,
             candidatoAtual, coordenadaCandidatoX, coordenadaCandidatoY,
      input  enableBusca, raio, raioAtualizado, ocupado, pronto, encontrado,
             melhorDistancia, melhorX, melhorY, melhorQuadrante, erroTimeout
   );

   modport slave (
      input  iniciar, raioMaximo, acabouCalculoLocal, operacaoFinalizada,
             candidatoAtual, coordenadaCandidatoX, coordenadaCandidatoY,
      output enableBusca, raio, raioAtualizado, ocupado, pronto, encontrado,
             melhorDistancia, melhorX, melhorY, melhorQuadrante, erroTimeout
   );
endinterface
`default_nettype wire

// File: rtl/controle_busca_raio.sv
`default_nettype none
// ============================================================================
// Module      : controle_busca_raio
// Description : Expanding-radius search controller. Drives four quadrant
//               searchers with a common enable and a radius that grows from 1
//               up to raioMaximo (or the grid edge). After every radius it
//               waits for all still-active quadrants, lets their result
//               registers settle, and picks the closest valid candidate.
//               A per-radius cycle budget aborts a stuck search.
// Ports       : clock, reset    - rising-edge clock, synchronous active-high
//               bus (slave)     - start/raioMaximo in, quadrant reports in,
//                                 enableBusca/raio/raioAtualizado out,
//                                 ocupado/pronto/encontrado/erroTimeout out,
//                                 melhorDistancia/X/Y/Quadrante out
// Revision    : 1.0 - initial release
// ============================================================================
module controle_busca_raio #(
   parameter int TamanhoMalha     = 20,
   parameter int tamanhoDistancia = 8,
   parameter int LimiteCiclos     = 1023
) (
   input  logic                  clock,
   input  logic                  reset,
   controle_busca_raio_if.slave  bus
);

   localparam int W  = tamanhoDistancia;
   localparam int CW = $clog2(LimiteCiclos + 1);

   localparam logic [W-1:0]  c_RAIO_LIMITE   = W'(TamanhoMalha - 1);
   localparam logic [CW-1:0] c_CONT_FIM      = CW'(LimiteCiclos - 1);
   localparam logic [W-1:0]  c_SEM_CANDIDATO = '1;

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      AGUARDA_LOCAL = 3'd1,
      ESTABILIZA    = 3'd2,
      AVALIA        = 3'd3,
      AVANCA_RAIO   = 3'd4,
      CONCLUIDO     = 3'd5
   } estado_t;

   estado_t         r_estado;
   logic [W-1:0]    r_raio;
   logic [W-1:0]    r_raio_max;
   logic [3:0]      r_ativo;
   logic [CW-1:0]   r_contador;
   logic            r_estab;
   logic            r_enable;
   logic            r_raio_atualizado;
   logic            r_ocupado;
   logic            r_pronto;
   logic            r_encontrado;
   logic            r_erro;
   logic [W-1:0]    r_melhor_dist;
   logic [W-1:0]    r_melhor_x;
   logic [W-1:0]    r_melhor_y;
   logic [1:0]      r_melhor_q;

   // Registered copies of the searcher results; selection only looks at these
   logic [3:0]      r_fin;
   logic [4*W-1:0]  r_cand;
   logic [4*W-1:0]  r_cx;
   logic [4*W-1:0]  r_cy;

   logic            w_valido;
   logic [1:0]      w_idx;
   logic [W-1:0]    w_dist;
   logic [3:0]      w_ativo_novo;

   // Minimum distance among active quadrants holding a real candidate.
   // Strict '<' keeps the lower index on ties.
   always_comb begin
      w_valido = 1'b0;
      w_idx    = 2'd0;
      w_dist   = '1;
      for (int q = 0; q < 4; q++) begin
         if (r_ativo[q] && (r_cand[q*W +: W] != c_SEM_CANDIDATO) &&
             (!w_valido || (r_cand[q*W +: W] < w_dist))) begin
            w_valido = 1'b1;
            w_idx    = 2'(q);
            w_dist   = r_cand[q*W +: W];
         end
      end
   end

   assign w_ativo_novo = r_ativo & ~r_fin;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado          <= OCIOSO;
         r_raio            <= '0;
         r_raio_max        <= '0;
         r_ativo           <= 4'b0000;
         r_contador        <= '0;
         r_estab           <= 1'b0;
         r_enable          <= 1'b0;
         r_raio_atualizado <= 1'b0;
         r_ocupado         <= 1'b0;
         r_pronto          <= 1'b0;
         r_encontrado      <= 1'b0;
         r_erro            <= 1'b0;
         r_melhor_dist     <= '0;
         r_melhor_x        <= '0;
         r_melhor_y        <= '0;
         r_melhor_q        <= 2'd0;
         r_fin             <= 4'b0000;
         r_cand            <= '1;
         r_cx              <= '0;
         r_cy              <= '0;
      end else begin
         r_fin             <= bus.operacaoFinalizada;
         r_cand            <= bus.candidatoAtual;
         r_cx              <= bus.coordenadaCandidatoX;
         r_cy              <= bus.coordenadaCandidatoY;
         r_raio_atualizado <= 1'b0;
         r_pronto          <= 1'b0;

         case (r_estado)
            OCIOSO: begin
               if (bus.iniciar) begin
                  r_ocupado     <= 1'b1;
                  r_encontrado  <= 1'b0;
                  r_erro        <= 1'b0;
                  r_melhor_dist <= '0;
                  r_melhor_x    <= '0;
                  r_melhor_y    <= '0;
                  r_melhor_q    <= 2'd0;
                  r_raio_max    <= bus.raioMaximo;
                  r_contador    <= '0;
                  if (bus.raioMaximo != '0) begin
                     r_raio   <= W'(1);
                     r_enable <= 1'b1;
                     r_ativo  <= 4'b1111;
                     r_estado <= AGUARDA_LOCAL;
                  end else begin
                     // Nothing to search: report an empty result at once
                     r_raio   <= '0;
                     r_ativo  <= 4'b0000;
                     r_pronto <= 1'b1;
                     r_estado <= CONCLUIDO;
                  end
               end
            end

            AGUARDA_LOCAL: begin
               if (r_contador == c_CONT_FIM) begin
                  r_erro       <= 1'b1;
                  r_encontrado <= 1'b0;
                  r_enable     <= 1'b0;
                  r_pronto     <= 1'b1;
                  r_estado     <= CONCLUIDO;
               end else begin
                  r_contador <= r_contador + CW'(1);
                  // Dropped quadrants are masked out, so they cannot stall us
                  if ((bus.acabouCalculoLocal & r_ativo) == r_ativo) begin
                     r_estab  <= 1'b0;
                     r_estado <= ESTABILIZA;
                  end
               end
            end

            ESTABILIZA: begin
               // Two cycles so the searchers' result registers and our
               // input copies both reflect the finished radius
               if (r_contador == c_CONT_FIM) begin
                  r_erro       <= 1'b1;
                  r_encontrado <= 1'b0;
                  r_enable     <= 1'b0;
                  r_pronto     <= 1'b1;
                  r_estado     <= CONCLUIDO;
               end else begin
                  r_contador <= r_contador + CW'(1);
                  r_estab    <= 1'b1;
                  if (r_estab) begin
                     r_estado <= AVALIA;
                  end
               end
            end

            AVALIA: begin
               if (w_valido) begin
                  r_encontrado  <= 1'b1;
                  r_melhor_dist <= w_dist;
                  r_melhor_q    <= w_idx;
                  r_melhor_x    <= r_cx[w_idx*W +: W];
                  r_melhor_y    <= r_cy[w_idx*W +: W];
                  r_enable      <= 1'b0;
                  r_pronto      <= 1'b1;
                  r_estado      <= CONCLUIDO;
               end else begin
                  r_ativo <= w_ativo_novo;
                  if ((w_ativo_novo == 4'b0000) || (r_raio == r_raio_max) ||
                      (r_raio == c_RAIO_LIMITE)) begin
                     r_encontrado <= 1'b0;
                     r_enable     <= 1'b0;
                     r_pronto     <= 1'b1;
                     r_estado     <= CONCLUIDO;
                  end else begin
                     // New radius becomes visible together with its pulse
                     r_raio            <= r_raio + W'(1);
                     r_raio_atualizado <= 1'b1;
                     r_contador        <= '0;
                     r_estado          <= AVANCA_RAIO;
                  end
               end
            end

            AVANCA_RAIO: begin
               r_contador <= '0;
               r_estado   <= AGUARDA_LOCAL;
            end

            CONCLUIDO: begin
               r_enable  <= 1'b0;
               r_ocupado <= 1'b0;
               r_estado  <= OCIOSO;
            end

            default: begin
               r_enable  <= 1'b0;
               r_ocupado <= 1'b0;
               r_estado  <= OCIOSO;
            end
         endcase
      end
   end

   assign bus.enableBusca     = r_enable;
   assign bus.raio            = r_raio;
   assign bus.raioAtualizado  = r_raio_atualizado;
   assign bus.ocupado         = r_ocupado;
   assign bus.pronto          = r_pronto;
   assign bus.encontrado      = r_encontrado;
   assign bus.erroTimeout     = r_erro;
   assign bus.melhorDistancia = r_melhor_dist;
   assign bus.melhorX         = r_melhor_x;
   assign bus.melhorY         = r_melhor_y;
   assign bus.melhorQuadrante = r_melhor_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_busca_raio.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_busca_raio
// Description : Self-checking bench for controle_busca_raio. A scenario table
//               (per radius, per quadrant) feeds a searcher responder; a
//               search-level reference model predicts the result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_busca_raio;

   localparam int W      = 8;
   localparam int LIMITE = 15;
   localparam int MALHA  = 20;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   controle_busca_raio_if #(.tamanhoDistancia(W)) bus ();

   controle_busca_raio #(
      .TamanhoMalha    (MALHA),
      .tamanhoDistancia(W),
      .LimiteCiclos    (LIMITE)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Scenario table
   logic [W-1:0] s_dist [0:31][0:3];
   logic [W-1:0] s_x    [0:31][0:3];
   logic [W-1:0] s_y    [0:31][0:3];
   logic [3:0]   s_fin  [0:31];
   int           s_delay[0:31];
   logic [3:0]   s_hang;

   // Searcher responder: reports each radius after s_delay cycles
   int         rsp_cnt  = 0;
   logic       rsp_prev = 1'b0;
   logic [3:0] rsp_gone = 4'b0000;
   always @(negedge clock) begin
      if (!bus.enableBusca) begin
         bus.acabouCalculoLocal   = 4'b0000;
         bus.operacaoFinalizada   = 4'b0000;
         bus.candidatoAtual       = '1;
         bus.coordenadaCandidatoX = '0;
         bus.coordenadaCandidatoY = '0;
         rsp_gone                 = 4'b0000;
      end else begin
         if (bus.raioAtualizado || !rsp_prev) begin
            rsp_cnt  = 0;
            rsp_gone = rsp_gone | bus.operacaoFinalizada;
            bus.acabouCalculoLocal = 4'b0000;
            bus.operacaoFinalizada = rsp_gone;
            bus.candidatoAtual     = '1;
         end else begin
            rsp_cnt++;
         end
         if (rsp_cnt >= s_delay[int'(bus.raio)]) begin
            for (int q = 0; q < 4; q++) begin
               if (rsp_gone[q]) begin
                  bus.acabouCalculoLocal[q]   = 1'b0;
                  bus.operacaoFinalizada[q]   = 1'b1;
                  bus.candidatoAtual[q*W +: W] = '1;
               end else begin
                  bus.acabouCalculoLocal[q]   = !s_hang[q];
                  bus.operacaoFinalizada[q]   = s_fin[int'(bus.raio)][q];
                  bus.candidatoAtual[q*W +: W] = s_dist[int'(bus.raio)][q];
               end
               bus.coordenadaCandidatoX[q*W +: W] = s_x[int'(bus.raio)][q];
               bus.coordenadaCandidatoY[q*W +: W] = s_y[int'(bus.raio)][q];
            end
         end
      end
      rsp_prev = bus.enableBusca;
   end

   // Monitor, sampled 2 time units after the rising edge
   int mon_pulses = 0;
   int mon_pronto = 0;
   int mon_en     = 0;
   always @(posedge clock) begin
      #2;
      if (bus.raioAtualizado === 1'b1) mon_pulses++;
      if (bus.enableBusca === 1'b1)    mon_en++;
      if (bus.pronto === 1'b1)         mon_pronto++;
   end

   // Reference model outputs
   logic         m_found, m_timeout;
   logic [W-1:0] m_dist, m_x, m_y, m_raio;
   logic [1:0]   m_q;
   int           m_pulses;

   task automatic clear_scenario();
      for (int r = 0; r < 32; r++) begin
         s_fin[r]   = 4'b0000;
         s_delay[r] = $urandom_range(0, 4);
         for (int q = 0; q < 4; q++) begin
            s_dist[r][q] = '1;
            s_x[r][q]    = W'($urandom);
            s_y[r][q]    = W'($urandom);
         end
      end
      s_hang = 4'b0000;
   endtask

   // Walk the radii the way the search is described: grow until a candidate
   // appears, every quadrant quits, or the radius/grid bound is hit.
   task automatic model_run(input int rmax);
      logic [3:0] at;
      int r;
      bit done;
      m_found = 0; m_timeout = 0; m_dist = '0; m_x = '0; m_y = '0;
      m_q = 2'd0; m_raio = '0; m_pulses = 0;
      if (rmax == 0) return;
      at = 4'hF; r = 1; done = 0;
      while (!done) begin
         m_raio = W'(r);
         if ((s_hang & at) != 0) begin
            m_timeout = 1; done = 1;
         end else begin
            for (int q = 0; q < 4; q++) begin
               if (at[q] && s_dist[r][q] != '1 && (!m_found || s_dist[r][q] < m_dist)) begin
                  m_found = 1; m_dist = s_dist[r][q]; m_q = 2'(q);
                  m_x = s_x[r][q]; m_y = s_y[r][q];
               end
            end
            if (m_found) done = 1;
            else begin
               at = at & ~s_fin[r];
               if (at == 0 || r == rmax || r == MALHA - 1) done = 1;
               else begin m_pulses++; r++; end
            end
         end
      end
   endtask

   // Stimulus only: start a search and wait (bounded) for its pronto
   task automatic run_search(input logic [W-1:0] rmax, output bit ok,
                             output int pulses, output int prontos, output int en_cyc);
      int p0, r0, e0;
      @(negedge clock);
      p0 = mon_pulses; r0 = mon_pronto; e0 = mon_en;
      bus.iniciar = 1'b1; bus.raioMaximo = rmax;
      @(negedge clock);
      bus.iniciar = 1'b0;
      ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         if (mon_pronto != r0) ok = 1;
         else @(negedge clock);
      end
      repeat (3) @(negedge clock);
      pulses = mon_pulses - p0; prontos = mon_pronto - r0; en_cyc = mon_en - e0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      n_checks++;
      if ({bus.enableBusca, bus.raioAtualizado, bus.ocupado, bus.pronto} !== 4'b0000) begin
         $display("FAIL reset_ctrl: got %b expected 0000", {bus.enableBusca, bus.raioAtualizado, bus.ocupado, bus.pronto});
         n_errors++;
      end
      n_checks++;
      if (bus.raio !== '0) begin
         $display("FAIL reset_raio: got %0d expected 0", bus.raio); n_errors++;
      end
      n_checks++;
      if ({bus.encontrado, bus.erroTimeout, bus.melhorDistancia, bus.melhorX, bus.melhorY, bus.melhorQuadrante} !== '0) begin
         $display("FAIL reset_result: got enc=%b err=%b d=%0d x=%0d y=%0d q=%0d expected all 0",
                  bus.encontrado, bus.erroTimeout, bus.melhorDistancia, bus.melhorX, bus.melhorY, bus.melhorQuadrante);
         n_errors++;
      end
   endtask

   task automatic test_single_candidate();
      bit ok; int p, pr, en;
      clear_scenario();
      s_dist[1][1] = 8'd3; s_x[1][1] = 8'd7; s_y[1][1] = 8'd4;
      run_search(8'd5, ok, p, pr, en);
      n_checks++;
      if (!ok || pr != 1) begin
         $display("FAIL single_pronto: got ok=%0d pronto_pulses=%0d expected 1/1", ok, pr); n_errors++;
      end
      n_checks++;
      if ({bus.encontrado, bus.melhorDistancia, bus.melhorQuadrante, bus.melhorX, bus.melhorY, bus.raio} !==
          {1'b1, 8'd3, 2'd1, 8'd7, 8'd4, 8'd1}) begin
         $display("FAIL single_result: got enc=%b d=%0d q=%0d x=%0d y=%0d raio=%0d expected 1 3 1 7 4 1",
                  bus.encontrado, bus.melhorDistancia, bus.melhorQuadrante, bus.melhorX, bus.melhorY, bus.raio);
         n_errors++;
      end
   endtask

   task automatic test_tie_at_radius3();
      bit ok; int p, pr, en;
      clear_scenario();
      s_dist[3][0] = 8'd4; s_dist[3][3] = 8'd4;
      run_search(8'd6, ok, p, pr, en);
      n_checks++;
      if (!ok || p != 2) begin
         $display("FAIL tie_pulses: got ok=%0d raioAtualizado=%0d expected 1/2", ok, p); n_errors++;
      end
      n_checks++;
      if ({bus.encontrado, bus.melhorQuadrante, bus.melhorDistancia, bus.melhorX} !== {1'b1, 2'd0, 8'd4, s_x[3][0]}) begin
         $display("FAIL tie_result: got enc=%b q=%0d d=%0d x=%0d expected 1 0 4 %0d",
                  bus.encontrado, bus.melhorQuadrante, bus.melhorDistancia, bus.melhorX, s_x[3][0]);
         n_errors++;
      end
   endtask

   task automatic test_exhausted();
      bit ok; int p, pr, en;
      clear_scenario();
      run_search(8'd2, ok, p, pr, en);
      n_checks++;
      if (!ok || p != 1 || pr != 1) begin
         $display("FAIL exhausted_pulses: got ok=%0d upd=%0d pronto=%0d expected 1/1/1", ok, p, pr); n_errors++;
      end
      n_checks++;
      if ({bus.encontrado, bus.erroTimeout, bus.raio, bus.ocupado} !== {1'b0, 1'b0, 8'd2, 1'b0}) begin
         $display("FAIL exhausted_result: got enc=%b err=%b raio=%0d ocup=%b expected 0 0 2 0",
                  bus.encontrado, bus.erroTimeout, bus.raio, bus.ocupado);
         n_errors++;
      end
   endtask

   task automatic test_grid_limit();
      bit ok; int p, pr, en;
      clear_scenario();
      run_search(8'd40, ok, p, pr, en);
      n_checks++;
      if (!ok || p != MALHA - 2 || bus.raio !== 8'(MALHA - 1) || bus.encontrado !== 1'b0) begin
         $display("FAIL grid_limit: got ok=%0d upd=%0d raio=%0d enc=%b expected 1 %0d %0d 0",
                  ok, p, bus.raio, bus.encontrado, MALHA - 2, MALHA - 1);
         n_errors++;
      end
   endtask

   task automatic test_timeout();
      bit ok; int p, pr, en;
      clear_scenario();
      s_hang = 4'b0100;
      s_dist[1][0] = 8'd1;
      run_search(8'd5, ok, p, pr, en);
      n_checks++;
      if (!ok || en != LIMITE) begin
         $display("FAIL timeout_cycles: got ok=%0d wait_cycles=%0d expected 1/%0d", ok, en, LIMITE); n_errors++;
      end
      n_checks++;
      if ({bus.erroTimeout, bus.encontrado, bus.enableBusca, bus.melhorDistancia} !== {1'b1, 1'b0, 1'b0, 8'd0}) begin
         $display("FAIL timeout_result: got err=%b enc=%b en=%b d=%0d expected 1 0 0 0",
                  bus.erroTimeout, bus.encontrado, bus.enableBusca, bus.melhorDistancia);
         n_errors++;
      end
   endtask

   task automatic test_drop_quadrant();
      bit ok; int p, pr, en;
      clear_scenario();
      s_fin[1][0] = 1'b1;
      s_dist[2][0] = 8'd1;
      s_dist[2][2] = 8'd9;
      run_search(8'd5, ok, p, pr, en);
      n_checks++;
      if (!ok || bus.erroTimeout !== 1'b0 || p != 1) begin
         $display("FAIL drop_progress: got ok=%0d err=%b upd=%0d expected 1 0 1", ok, bus.erroTimeout, p); n_errors++;
      end
      n_checks++;
      if ({bus.encontrado, bus.melhorQuadrante, bus.melhorDistancia} !== {1'b1, 2'd2, 8'd9}) begin
         $display("FAIL drop_result: got enc=%b q=%0d d=%0d expected 1 2 9",
                  bus.encontrado, bus.melhorQuadrante, bus.melhorDistancia);
         n_errors++;
      end
   endtask

   task automatic test_zero_radius();
      bit ok; int p, pr, en;
      clear_scenario();
      s_dist[1][0] = 8'd2;
      run_search(8'd0, ok, p, pr, en);
      n_checks++;
      if (!ok || pr != 1 || en != 0 || bus.encontrado !== 1'b0) begin
         $display("FAIL zero_radius: got ok=%0d pronto=%0d en_cycles=%0d enc=%b expected 1 1 0 0",
                  ok, pr, en, bus.encontrado);
         n_errors++;
      end
   endtask

   task automatic test_start_while_busy();
      int p0, r0;
      bit ok;
      clear_scenario();
      for (int r = 0; r < 32; r++) s_delay[r] = 4;
      @(negedge clock);
      p0 = mon_pulses; r0 = mon_pronto;
      bus.iniciar = 1'b1; bus.raioMaximo = 8'd2;
      @(negedge clock);
      bus.iniciar = 1'b0;
      repeat (2) @(negedge clock);
      bus.iniciar = 1'b1; bus.raioMaximo = 8'd9;
      repeat (2) @(negedge clock);
      bus.iniciar = 1'b0;
      ok = 0;
      for (int i = 0; i < 1000 && !ok; i++) begin
         if (mon_pronto != r0) ok = 1;
         else @(negedge clock);
      end
      repeat (3) @(negedge clock);
      n_checks++;
      if (!ok || (mon_pulses - p0) != 1 || bus.raio !== 8'd2 || (mon_pronto - r0) != 1) begin
         $display("FAIL busy_ignore: got ok=%0d upd=%0d raio=%0d pronto=%0d expected 1 1 2 1",
                  ok, mon_pulses - p0, bus.raio, mon_pronto - r0);
         n_errors++;
      end
   endtask

   task automatic test_reset_mid_search();
      int r0;
      clear_scenario();
      s_hang = 4'b1111;
      s_dist[1][0] = 8'd5;
      @(negedge clock);
      r0 = mon_pronto;
      bus.iniciar = 1'b1; bus.raioMaximo = 8'd5;
      @(negedge clock);
      bus.iniciar = 1'b0;
      repeat (3) @(negedge clock);
      n_checks++;
      if (bus.ocupado !== 1'b1 || bus.enableBusca !== 1'b1) begin
         $display("FAIL midreset_busy: got ocup=%b en=%b expected 1 1", bus.ocupado, bus.enableBusca); n_errors++;
      end
      reset = 1'b1;
      @(posedge clock); #2;
      n_checks++;
      if ({bus.enableBusca, bus.ocupado, bus.pronto, bus.raio, bus.erroTimeout, bus.encontrado} !== '0) begin
         $display("FAIL midreset_outputs: got en=%b ocup=%b pronto=%b raio=%0d err=%b enc=%b expected all 0",
                  bus.enableBusca, bus.ocupado, bus.pronto, bus.raio, bus.erroTimeout, bus.encontrado);
         n_errors++;
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (LIMITE + 5) @(negedge clock);
      n_checks++;
      if (mon_pronto != r0 || bus.ocupado !== 1'b0) begin
         $display("FAIL midreset_no_pronto: got pronto_pulses=%0d ocup=%b expected 0 0", mon_pronto - r0, bus.ocupado);
         n_errors++;
      end
   endtask

   task automatic test_random();
      bit ok; int p, pr, en;
      int rmax;
      for (int it = 0; it < 40; it++) begin
         clear_scenario();
         for (int r = 1; r < MALHA; r++) begin
            for (int q = 0; q < 4; q++) begin
               if ($urandom_range(0, 9) == 0) s_dist[r][q] = W'($urandom_range(0, 15));
               if ($urandom_range(0, 11) == 0) s_fin[r][q] = 1'b1;
            end
         end
         for (int q = 0; q < 4; q++) if ($urandom_range(0, 19) == 0) s_hang[q] = 1'b1;
         rmax = $urandom_range(1, 22);
         model_run(rmax);
         run_search(W'(rmax), ok, p, pr, en);
         n_checks++;
         if (!ok || pr != 1 || p != m_pulses) begin
            $display("FAIL rnd%0d_flow: got ok=%0d pronto=%0d upd=%0d expected 1 1 %0d", it, ok, pr, p, m_pulses);
            n_errors++;
         end
         n_checks++;
         if ({bus.encontrado, bus.erroTimeout, bus.raio} !== {m_found, m_timeout, m_raio}) begin
            $display("FAIL rnd%0d_status: got enc=%b err=%b raio=%0d expected %b %b %0d",
                     it, bus.encontrado, bus.erroTimeout, bus.raio, m_found, m_timeout, m_raio);
            n_errors++;
         end
         n_checks++;
         if ({bus.melhorDistancia, bus.melhorQuadrante, bus.melhorX, bus.melhorY} !== {m_dist, m_q, m_x, m_y}) begin
            $display("FAIL rnd%0d_best: got d=%0d q=%0d x=%0d y=%0d expected %0d %0d %0d %0d",
                     it, bus.melhorDistancia, bus.melhorQuadrante, bus.melhorX, bus.melhorY,
                     m_dist, m_q, m_x, m_y);
            n_errors++;
         end
      end
   endtask

   initial begin
      bus.iniciar    = 1'b0;
      bus.raioMaximo = '0;
      clear_scenario();
      test_reset();
      test_single_candidate();
      test_tie_at_radius3();
      test_exhausted();
      test_grid_limit();
      test_timeout();
      test_drop_quadrant();
      test_zero_radius();
      test_start_while_busy();
      test_reset_mid_search();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
